// File: rtl/enhanced_datapath.sv
// ---------------------------------------------------------------------------
// enhanced_datapath
//
// Datapath of the enhanced 8-bit accumulator processor. It holds PC, IR, the
// accumulator A, the memory-data register MDR and a unified 2**AW x DW memory.
// Each cycle it executes the control word driven by the control-unit FSM and
// returns the opcode and the condition flags the FSM branches on. A separate
// program-load port fills memory from the board or a testbench.
//
// Optional feature macro: ENHANCED_DP_OVF_EN
//   defined     -> sticky signed-overflow flag on ADD/SUB accumulator loads
//   not defined -> ovf tied to 0, no overflow logic
//
// Ports:
//   clock      in   system clock, rising-edge active
//   reset      in   synchronous active-low reset (memory is not cleared)
//   IRload     in   IR <- MDR
//   JMPmux     in   PC source: 0 = PC+1, 1 = IR operand
//   PCload     in   PC <- selected source
//   Meminst    in   memory address: 0 = PC, 1 = IR operand
//   MemWr      in   M[IR operand] <- A
//   Asel[1:0]  in   A source: 00 add/sub, 01 in_data, 10 MDR, 11 zero
//   Aload      in   A <- selected source
//   Sub        in   ALU op: 0 = A+MDR, 1 = A-MDR
//   Halt       in   freeze IR, PC, A, ovf and MemWr writes
//   in_data    in   external input word (IN instruction)
//   prog_we    in   program-load write strobe (wins over MemWr)
//   prog_addr  in   program-load address
//   prog_data  in   program-load data
//   ir[2:0]    out  IR opcode field
//   Aeq0       out  A == 0
//   Apos       out  A sign bit clear (zero counts as positive)
//   out_data   out  A, for display
//   pc_out     out  PC, for display
//   ovf        out  sticky signed-overflow flag
// ---------------------------------------------------------------------------
module enhanced_datapath #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          IRload,
    input  logic          JMPmux,
    input  logic          PCload,
    input  logic          Meminst,
    input  logic          MemWr,
    input  logic [1:0]    Asel,
    input  logic          Aload,
    input  logic          Sub,
    input  logic          Halt,
    input  logic [DW-1:0] in_data,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic [2:0]    ir,
    output logic          Aeq0,
    output logic          Apos,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] pc_out,
    output logic          ovf
);

    localparam int DEPTH = 1 << AW;

    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_mdr;
    logic [DW-1:0] r_mem [DEPTH];

    logic [AW-1:0] w_addr;
    logic [AW-1:0] w_pc_next;
    logic [DW-1:0] w_alu;
    logic [DW-1:0] w_a_next;

`ifdef ENHANCED_DP_OVF_EN
    // Two's-complement overflow of r = a +/- b. For subtraction the operand
    // signs must differ; for addition they must match. In both cases the
    // result sign then differs from a.
    function automatic logic f_signed_ovf(
        input logic          sub,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] r
    );
        logic same_sign;
        same_sign = (a[DW-1] == b[DW-1]);
        if (sub) begin
            return !same_sign && (r[DW-1] != a[DW-1]);
        end else begin
            return same_sign && (r[DW-1] != a[DW-1]);
        end
    endfunction

    logic r_ovf;
    logic w_ovf;
`endif

    // Address, next-PC and accumulator-source selection.
    always_comb begin
        w_addr    = Meminst ? r_ir[AW-1:0] : r_pc;
        w_pc_next = JMPmux ? r_ir[AW-1:0] : (r_pc + {{(AW-1){1'b0}}, 1'b1});
        if (Sub) begin
            w_alu = r_a - r_mdr;
        end else begin
            w_alu = r_a + r_mdr;
        end
        case (Asel)
            2'b00:   w_a_next = w_alu;
            2'b01:   w_a_next = in_data;
            2'b10:   w_a_next = r_mdr;
            2'b11:   w_a_next = {DW{1'b0}};
            default: w_a_next = {DW{1'b0}};
        endcase
    end

    // Architectural registers. MDR keeps tracking memory even while halted so
    // the fetch sequence stays coherent after Halt is released.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc  <= {AW{1'b0}};
            r_ir  <= {DW{1'b0}};
            r_a   <= {DW{1'b0}};
            r_mdr <= {DW{1'b0}};
        end else begin
            r_mdr <= r_mem[w_addr];
            if (!Halt) begin
                if (IRload) begin
                    r_ir <= r_mdr;
                end
                if (PCload) begin
                    r_pc <= w_pc_next;
                end
                if (Aload) begin
                    r_a <= w_a_next;
                end
            end
        end
    end

    // Memory write port. Program load takes precedence and is honoured even
    // while reset is held; datapath stores are blocked by reset and Halt.
    always_ff @(posedge clock) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end else if (reset && MemWr && !Halt) begin
            r_mem[r_ir[AW-1:0]] <= r_a;
        end
    end

`ifdef ENHANCED_DP_OVF_EN
    // Overflow is only meaningful when A actually takes the ALU result.
    always_comb begin
        w_ovf = 1'b0;
        if (Aload && !Halt && (Asel == 2'b00)) begin
            w_ovf = f_signed_ovf(Sub, r_a, r_mdr, w_alu);
        end else begin
            w_ovf = 1'b0;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign ir       = r_ir[DW-1:DW-3];
    assign Aeq0     = (r_a == {DW{1'b0}});
    assign Apos     = ~r_a[DW-1];
    assign out_data = r_a;
    assign pc_out   = r_pc;

endmodule

// File: tb/tb_enhanced_datapath.sv
// ---------------------------------------------------------------------------
// tb_enhanced_datapath
//
// Bench acting as the control unit for enhanced_datapath. A behavioural model
// of the processor state computes the expected outcome of each instruction;
// the expectations are queued before the control word is driven and popped
// and compared once the datapath has clocked the instruction through.
// ---------------------------------------------------------------------------
module tb_enhanced_datapath;

    logic       clock;
    logic       reset;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;
    logic [7:0] in_data;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [2:0] ir;
    logic       Aeq0, Apos, ovf;
    logic [7:0] out_data;
    logic [4:0] pc_out;

    enhanced_datapath #(.AW(5), .DW(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .IRload   (IRload),
        .JMPmux   (JMPmux),
        .PCload   (PCload),
        .Meminst  (Meminst),
        .MemWr    (MemWr),
        .Asel     (Asel),
        .Aload    (Aload),
        .Sub      (Sub),
        .Halt     (Halt),
        .in_data  (in_data),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .ir       (ir),
        .Aeq0     (Aeq0),
        .Apos     (Apos),
        .out_data (out_data),
        .pc_out   (pc_out),
        .ovf      (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [7:0] m_mem [32];
    logic [4:0] m_pc;
    logic [7:0] m_ir;
    logic [7:0] m_a;
    logic [7:0] m_mdr;
    logic       m_ovf;

    int n_checks;
    int n_fail;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            0:       return out_data;
            1:       return {3'b000, pc_out};
            2:       return {5'b00000, ir};
            3:       return {7'b0000000, Aeq0};
            4:       return {7'b0000000, Apos};
            5:       return {7'b0000000, ovf};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic sb_push(input string tag, input int sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_push_state(input string tag);
        sb_push({tag, ".A"},    0, m_a);
        sb_push({tag, ".PC"},   1, {3'b000, m_pc});
        sb_push({tag, ".IR"},   2, {5'b00000, m_ir[7:5]});
        sb_push({tag, ".Aeq0"}, 3, {7'b0000000, (m_a == 8'h00)});
        sb_push({tag, ".Apos"}, 4, {7'b0000000, ~m_a[7]});
        sb_push({tag, ".ovf"},  5, {7'b0000000, m_ovf});
    endtask

    task automatic sb_drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_val(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic ctrl_idle();
        IRload = 1'b0; JMPmux = 1'b0; PCload = 1'b0; Meminst = 1'b0;
        MemWr  = 1'b0; Aload  = 1'b0; Sub    = 1'b0; Halt    = 1'b0;
        Asel   = 2'b00; prog_we = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 5'd0; m_ir = 8'h00; m_a = 8'h00; m_mdr = 8'h00; m_ovf = 1'b0;
    endtask

    // Assert reset for one edge and leave it asserted.
    task automatic hold_reset();
        ctrl_idle();
        reset = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic prog_write(input logic [4:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
        m_mem[a]  = d;
    endtask

    task automatic fetch_decode();
        ctrl_idle();
        tick();                              // fetch0: MDR <- M[PC]
        IRload = 1'b1; PCload = 1'b1;
        tick();                              // fetch1: IR <- MDR, PC <- PC+1
        ctrl_idle();
        m_ir = m_mem[m_pc];
        m_pc = m_pc + 5'd1;
        Meminst = 1'b1;
        tick();                              // decode: MDR <- M[operand]
        m_mdr = m_mem[m_ir[4:0]];
    endtask

    task automatic model_alu(input logic sub);
        logic [7:0] r;
        r = sub ? (m_a - m_mdr) : (m_a + m_mdr);
`ifdef ENHANCED_DP_OVF_EN
        if (sub) begin
            if ((m_a[7] != m_mdr[7]) && (r[7] != m_a[7])) m_ovf = 1'b1;
        end else begin
            if ((m_a[7] == m_mdr[7]) && (r[7] != m_a[7])) m_ovf = 1'b1;
        end
`endif
        m_a = r;
    endtask

    // Fetch, decode and execute one instruction: model first, then queue the
    // expectations, then drive the execute control word, then compare.
    task automatic run_instr(input string tag);
        logic [7:0] in_seq [3];
        logic       take;
        in_seq[0] = 8'h11; in_seq[1] = 8'h22; in_seq[2] = 8'h2A;
        fetch_decode();
        take = 1'b0;
        case (m_ir[7:5])
            3'b000: m_a = m_mdr;
            3'b001: m_mem[m_ir[4:0]] = m_a;
            3'b010: model_alu(1'b0);
            3'b011: model_alu(1'b1);
            3'b100: m_a = in_seq[2];
            3'b101: take = (m_a == 8'h00);
            3'b110: take = ~m_a[7];
            default: ;
        endcase
        if (take) m_pc = m_ir[4:0];
        sb_push_state(tag);
        Meminst = 1'b1;
        case (m_ir[7:5])
            3'b000: begin Aload = 1'b1; Asel = 2'b10; tick(); end
            3'b001: begin MemWr = 1'b1; tick(); end
            3'b010: begin Aload = 1'b1; Asel = 2'b00; tick(); end
            3'b011: begin Aload = 1'b1; Asel = 2'b00; Sub = 1'b1; tick(); end
            3'b100: begin
                Aload = 1'b1; Asel = 2'b01;
                for (int i = 0; i < 3; i++) begin
                    in_data = in_seq[i];
                    tick();
                end
            end
            3'b101, 3'b110: begin PCload = take; JMPmux = 1'b1; tick(); end
            default: begin
                // HALT: every state-changing control is attempted and must be ignored
                Halt = 1'b1; Aload = 1'b1; Asel = 2'b01; in_data = 8'h99;
                PCload = 1'b1; MemWr = 1'b1;
                tick();
                tick();
            end
        endcase
        ctrl_idle();
        sb_drain();
    endtask

    // Reload M[0] with LOAD addr under reset and execute it to read a word back.
    task automatic readback(input logic [4:0] addr, input string tag);
        hold_reset();
        prog_write(5'd0, {3'b000, addr});
        reset = 1'b1;
        run_instr(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ctrl_idle();
        in_data   = 8'h00;
        prog_addr = 5'd0;
        prog_data = 8'h00;
        reset     = 1'b0;
        tick();
        tick();
        model_reset();
        sb_push_state("reset");
        sb_drain();

        // LOAD 30 / ADD 31 / STORE 29 / HALT, program written while in reset
        hold_reset();
        prog_write(5'd0,  8'h1E);
        prog_write(5'd1,  8'h5F);
        prog_write(5'd2,  8'h3D);
        prog_write(5'd3,  8'hE0);
        prog_write(5'd30, 8'd5);
        prog_write(5'd31, 8'd7);
        reset = 1'b1;
        run_instr("p1_load");
        run_instr("p1_add");
        run_instr("p1_store");
        run_instr("p1_halt");
        chk_val("p1_A_final",  out_data, 8'd12);
        chk_val("p1_PC_final", {3'b000, pc_out}, 8'd4);
        readback(5'd29, "p1_m29");
        chk_val("p1_m29_is_12", out_data, 8'd12);

        // A=3, SUB 31 with M[31]=5
        hold_reset();
        prog_write(5'd0,  8'h1E);
        prog_write(5'd1,  8'h7F);
        prog_write(5'd30, 8'd3);
        prog_write(5'd31, 8'd5);
        reset = 1'b1;
        run_instr("sub_load");
        run_instr("sub_exec");
        chk_val("sub_A",    out_data, 8'hFE);
        chk_val("sub_Apos", {7'b0000000, Apos}, 8'd0);
        chk_val("sub_Aeq0", {7'b0000000, Aeq0}, 8'd0);

        // JZ taken (A=0), JZ not taken (A=1), then IN
        hold_reset();
        prog_write(5'd0,  8'h1C);
        prog_write(5'd1,  8'hAA);
        prog_write(5'd10, 8'h1B);
        prog_write(5'd11, 8'hAA);
        prog_write(5'd12, 8'h80);
        prog_write(5'd27, 8'd1);
        prog_write(5'd28, 8'd0);
        reset = 1'b1;
        run_instr("jz_load0");
        run_instr("jz_taken");
        chk_val("jz_taken_pc", {3'b000, pc_out}, 8'd10);
        run_instr("jz_load1");
        run_instr("jz_not_taken");
        chk_val("jz_not_taken_pc", {3'b000, pc_out}, 8'd12);
        run_instr("in_exec");
        chk_val("in_out_data", out_data, 8'h2A);

        // Reset in the middle of STORE 29 with A=12, PC=3
        hold_reset();
        prog_write(5'd0,  8'h1E);
        prog_write(5'd1,  8'h5F);
        prog_write(5'd2,  8'h3D);
        prog_write(5'd3,  8'h1D);
        prog_write(5'd29, 8'h33);
        prog_write(5'd30, 8'd5);
        prog_write(5'd31, 8'd7);
        reset = 1'b1;
        run_instr("rm_load");
        run_instr("rm_add");
        fetch_decode();
        chk_val("rm_pre_A",  out_data, 8'd12);
        chk_val("rm_pre_PC", {3'b000, pc_out}, 8'd3);
        model_reset();
        sb_push_state("rm_reset");
        Meminst = 1'b1; MemWr = 1'b1; Aload = 1'b1; PCload = 1'b1; IRload = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ctrl_idle();
        sb_drain();
        readback(5'd29, "rm_m29");
        chk_val("rm_m29_kept", out_data, 8'h33);

        // prog_we and MemWr to address 29 in the same cycle
        hold_reset();
        prog_write(5'd0, 8'h1E);
        reset = 1'b1;
        run_instr("pw_load");
        run_instr("pw_add");
        fetch_decode();
        m_mem[29] = 8'h5A;
        sb_push_state("pw_store");
        Meminst = 1'b1; MemWr = 1'b1;
        prog_we = 1'b1; prog_addr = 5'd29; prog_data = 8'h5A;
        tick();
        ctrl_idle();
        sb_drain();
        run_instr("pw_load29");
        chk_val("pw_m29_prog_wins", out_data, 8'h5A);

        // Signed overflow: 0x7F + 1, then + 0
        hold_reset();
        prog_write(5'd0,  8'h1E);
        prog_write(5'd1,  8'h5F);
        prog_write(5'd2,  8'h5C);
        prog_write(5'd28, 8'h00);
        prog_write(5'd30, 8'h7F);
        prog_write(5'd31, 8'h01);
        reset = 1'b1;
        run_instr("ov_load");
        run_instr("ov_add1");
        chk_val("ov_A", out_data, 8'h80);
        run_instr("ov_add0");
`ifdef ENHANCED_DP_OVF_EN
        chk_val("ov_sticky", {7'b0000000, ovf}, 8'd1);
`else
        chk_val("ov_tied0", {7'b0000000, ovf}, 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enhanced_datapath.md
# enhanced_datapath

Datapath for the enhanced 8-bit accumulator processor: holds PC, IR, accumulator A, a memory-data register (MDR) and a 32x8 unified memory. It executes the control word issued each cycle by the processor control-unit FSM and returns the opcode and condition flags that the FSM branches on. It sits beside the control unit at the processor top level. It also provides a program-load port for filling memory from the board or testbench.

## Interface
Parameters:
- `AW`, 5: memory address width (PC and IR operand field).
- `DW`, 8: data width (A, MDR, memory words, IR).

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous active-low reset.
- `IRload`  in  1  IR <- MDR.
- `JMPmux`  in  1  PC source: 0 = PC+1, 1 = IR[4:0].
- `PCload`  in  1  PC <- selected source.
- `Meminst`  in  1  memory address: 0 = PC, 1 = IR[4:0].
- `MemWr`  in  1  M[IR[4:0]] <- A.
- `Asel`  in  2  A source: 00 = add/sub result, 01 = `in_data`, 10 = MDR, 11 = 8'h00.
- `Aload`  in  1  A <- selected source.
- `Sub`  in  1  ALU op: 0 = A+MDR, 1 = A-MDR.
- `Halt`  in  1  freeze architectural state.
- `in_data`  in  8  external input word (IN instruction).
- `prog_we`  in  1  program-load write strobe.
- `prog_addr`  in  5  program-load address.
- `prog_data`  in  8  program-load data.
- `ir`  out  3  IR[7:5] opcode to the control unit.
- `Aeq0`  out  1  A == 0.
- `Apos`  out  1  A[7] == 0 (A >= 0; zero counts as positive).
- `out_data`  out  8  A, for display.
- `pc_out`  out  5  PC, for display.
- `ovf`  out  1  sticky signed-overflow flag (see Configuration).

## Operation
- Instruction word: [7:5] opcode, [4:0] operand address. The opcodes are 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 IN, 101 JZ, 110 JPOS, 111 HALT. Decoding is done by the control unit; the datapath only exposes `ir`.
- Address mux: `addr = Meminst ? IR[4:0] : PC`.
- MDR is updated every cycle with M[addr] (synchronous read). Read-before-write: when the same cycle writes that address, MDR receives the old word.
- IRload: IR <- MDR. The fetch state relies on MDR having captured M[PC] in the preceding cycle.
- PCload: PC <- JMPmux ? IR[4:0] : PC+1. PC+1 wraps 31 -> 0.
- Aload with Asel=00: A <- A +/- MDR, mod 256, two's complement.
- Memory write: if `prog_we`=1, M[prog_addr] <- prog_data. Otherwise, if MemWr=1 and Halt=0, M[IR[4:0]] <- A. When both are asserted, `prog_we` wins and the MemWr write is dropped.
- Halt=1: IR, PC, A, `ovf` and MemWr writes are frozen. MDR keeps tracking, and `prog_we` still writes.
- Reset (reset=0 at an edge) sets PC=0, IR=0, A=0, MDR=0 and `ovf`=0. Memory contents are preserved, and `prog_we` writes are accepted while reset is held. Reset takes priority over every control input, including in mid-instruction.
- Output values during/after reset: `ir`=000, `Aeq0`=1, `Apos`=1, `out_data`=0, `pc_out`=0, `ovf`=0.

## Timing
- All control inputs are sampled at the rising edge. Register effects are visible one cycle later.
- `ir`, `Aeq0`, `Apos`, `out_data` and `pc_out` are combinational from registers, with no input-to-output combinational path. Flags reflect A in the same cycle that A changes.
- Expected control sequence: fetch0 (Meminst=0; MDR <- M[PC]) -> fetch1 (IRload, PCload, JMPmux=0) -> decode (Meminst=1; MDR <- M[operand]) -> execute.
- Latency of `prog_we`: the word is readable into MDR on the following edge.
- IN: A loads `in_data` on every edge while Aload=1 and Asel=01. The final value is the one sampled on the last such edge.

## Configuration
- `ENHANCED_DP_OVF_EN` defined: `ovf` is set when an Aload with Asel=00 produces signed overflow. For ADD, overflow means both operands have the same sign and the result sign differs. For SUB, the operands have different signs and the result sign differs from A. The flag is sticky and cleared only by reset.
- Not defined: `ovf` is tied to 0 and no overflow logic is synthesized.

## Test plan
- Load program M[0]=8'h1E (LOAD 30), M[1]=8'h5F (ADD 31), M[2]=8'h3D (STORE 29), M[3]=8'hE0 (HALT), M[30]=5, M[31]=7, and drive the control sequence -> M[29]=12, A=12, `pc_out`=4, and A frozen after HALT.
- A=3, M[31]=5, run SUB 31 -> A=8'hFE, `Apos`=0, `Aeq0`=0.
- JZ 10 with A=0 -> PC=10. Same instruction with A=1 -> PC unchanged from the post-fetch value.
- IN with `in_data`=8'h2A, Aload held 3 cycles -> A=8'h2A, `out_data`=8'h2A.
- Assert reset mid-execute (A=12, PC=3) -> the next cycle shows PC=0, A=0, IR=0, and memory is unchanged. A simultaneous `prog_we` to address 29 while MemWr targets 29 -> the `prog_data` value is stored.
- With `ENHANCED_DP_OVF_EN`: A=8'h7F, ADD of 1 -> A=8'h80 and `ovf`=1, and `ovf` stays 1 after a later ADD of 0. Without the macro, `ovf`=0 throughout.
